// File: rtl/cash_dispense_if.sv
// Purpose : front-end and note-mechanism signal bundle for cash_dispense_sequencer.
// Latency : none, wires only.
// Backpressure: note_req is held until note_ack or timeout; start is only taken when busy is low.
// Ports: master = front-end/mechanism side (drives start, amount, cancel, refill, note_ack);
//        slave  = sequencer side (drives note_req/sel, status pulses, counters, inventories).
interface cash_dispense_if #(
   parameter int AMT_W = 14,
   parameter int CNT_W = 8
);
   logic             start;
   logic [AMT_W-1:0] amount;
   logic             cancel;
   logic             refill;
   logic             note_ack;
   logic             note_req;
   logic [1:0]       note_sel;
   logic             busy;
   logic             done;
   logic             error;
   logic [1:0]       err_code;
   logic [9:0]       notes_dispensed;
   logic [AMT_W-1:0] cash_dispensed;
   logic [CNT_W-1:0] inv_100;
   logic [CNT_W-1:0] inv_50;
   logic [CNT_W-1:0] inv_20;
   logic [CNT_W-1:0] inv_10;

   modport master (
      output start, amount, cancel, refill, note_ack,
      input  note_req, note_sel, busy, done, error, err_code,
             notes_dispensed, cash_dispensed, inv_100, inv_50, inv_20, inv_10
   );

   modport slave (
      input  start, amount, cancel, refill, note_ack,
      output note_req, note_sel, busy, done, error, err_code,
             notes_dispensed, cash_dispensed, inv_100, inv_50, inv_20, inv_10
   );
endinterface

// File: rtl/cash_dispense_sequencer.sv
// Purpose : plans a greedy note mix against cassette inventory and dispenses it one note at a time.
// Latency : 1 accept + N plan + (k+2) per note + 1 finish; done/error are registered one-cycle pulses.
// Backpressure: each note_req waits up to ACK_TIMEOUT cycles for note_ack, then aborts with JAM.
// Ports: clk, rst (sync, active-high); bus (slave modport of cash_dispense_if) carries the
//        request/abort/refill inputs, note req/ack handshake, status pulses, counters and inventories.
module cash_dispense_sequencer #(
   parameter int AMT_W       = 14,
   parameter int MAX_AMT     = 7000,
   parameter int CNT_W       = 8,
   parameter int INIT_NOTES  = 10,
   parameter int ACK_TIMEOUT = 16
) (
   input logic             clk,
   input logic             rst,
   cash_dispense_if.slave  bus
);
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, PLAN, REQ, GAP, FINISH} state_t;

   // Denomination index: 0=100, 1=50, 2=20, 3=10 (same as note_sel).
   function automatic logic [AMT_W-1:0] denom(input logic [1:0] idx);
      case (idx)
         2'd0:    denom = AMT_W'(100);
         2'd1:    denom = AMT_W'(50);
         2'd2:    denom = AMT_W'(20);
         default: denom = AMT_W'(10);
      endcase
   endfunction

   state_t           state, state_d;
   logic [CNT_W-1:0] inv [4];
   logic [CNT_W-1:0] tmp [4];
   logic [9:0]       p   [4];
   logic [AMT_W-1:0] rem;
   logic [TO_W-1:0]  to_cnt;
   logic [1:0]       cur_sel, next_sel;
   logic [9:0]       notes_cnt;
   logic [AMT_W-1:0] cash_cnt;
   logic             done_r, error_r;
   logic [1:0]       err_code_r;

   logic             accept, bad_amt, do_refill, alloc, insuff, ack_take, jam, finish;
   logic             amt_bad;
   logic             plan_ok, pn_ok, gn_ok;
   logic [1:0]       plan_idx, pn_idx, gn_idx;
   logic [AMT_W-1:0] rem_after;
   logic [9:0]       p_plus [4];

   assign amt_bad = (bus.amount == '0) || (bus.amount > AMT_W'(MAX_AMT)) ||
                    ((bus.amount % AMT_W'(10)) != '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      bad_amt   = 1'b0;
      do_refill = 1'b0;
      alloc     = 1'b0;
      insuff    = 1'b0;
      ack_take  = 1'b0;
      jam       = 1'b0;
      finish    = 1'b0;
      next_sel  = cur_sel;
      plan_ok   = 1'b0;
      plan_idx  = 2'd0;
      pn_ok     = 1'b0;
      pn_idx    = 2'd0;
      gn_ok     = 1'b0;
      gn_idx    = 2'd0;

      // Scan small-to-large so the last hit is the largest qualifying note.
      for (int i = 3; i >= 0; i--) begin
         if (tmp[i] != '0 && denom(2'(i)) <= rem) begin
            plan_ok  = 1'b1;
            plan_idx = 2'(i);
         end
      end
      rem_after = rem - denom(plan_idx);

      // Plan counts as they will be after this cycle's allocation, so the
      // first REQ can be chosen in the same cycle the plan completes.
      for (int i = 0; i < 4; i++)
         p_plus[i] = p[i] + {9'd0, (plan_ok && plan_idx == 2'(i))};
      for (int i = 3; i >= 0; i--) begin
         if (p_plus[i] != '0) begin
            pn_ok  = 1'b1;
            pn_idx = 2'(i);
         end
         if (p[i] != '0) begin
            gn_ok  = 1'b1;
            gn_idx = 2'(i);
         end
      end

      case (state)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (amt_bad) bad_amt = 1'b1;
               else         state_d = PLAN;
            end else if (bus.refill) begin
               do_refill = 1'b1;
            end
         end
         PLAN: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else if (plan_ok) begin
               alloc = 1'b1;
               if (rem_after == '0) begin
                  state_d  = REQ;
                  next_sel = pn_idx;
               end
            end else begin
               insuff  = 1'b1;
               state_d = IDLE;
            end
         end
         REQ: begin
            // An ack in the last allowed cycle still counts.
            if (bus.note_ack) begin
               ack_take = 1'b1;
               state_d  = GAP;
            end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
               jam     = 1'b1;
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gn_ok) begin
               state_d  = REQ;
               next_sel = gn_idx;
            end else begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            inv[i] <= CNT_W'(INIT_NOTES);
            tmp[i] <= '0;
            p[i]   <= '0;
         end
         rem        <= '0;
         to_cnt     <= '0;
         cur_sel    <= 2'd0;
         notes_cnt  <= '0;
         cash_cnt   <= '0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         err_code_r <= 2'd0;
      end else begin
         done_r  <= finish;
         error_r <= bad_amt | insuff | jam;
         cur_sel <= next_sel;

         if (accept) begin
            notes_cnt  <= '0;
            cash_cnt   <= '0;
            err_code_r <= bad_amt ? 2'd1 : 2'd0;
            if (!bad_amt) begin
               rem <= bus.amount;
               for (int i = 0; i < 4; i++) begin
                  tmp[i] <= inv[i];
                  p[i]   <= '0;
               end
            end
         end

         if (do_refill)
            for (int i = 0; i < 4; i++) inv[i] <= CNT_W'(INIT_NOTES);

         if (alloc) begin
            p[plan_idx]   <= p[plan_idx] + 10'd1;
            tmp[plan_idx] <= tmp[plan_idx] - CNT_W'(1);
            rem           <= rem_after;
         end

         if (insuff) err_code_r <= 2'd2;
         if (jam)    err_code_r <= 2'd3;

         if (state == REQ) to_cnt <= to_cnt + TO_W'(1);
         else              to_cnt <= '0;

         if (ack_take) begin
            inv[cur_sel] <= inv[cur_sel] - CNT_W'(1);
            p[cur_sel]   <= p[cur_sel] - 10'd1;
            notes_cnt    <= notes_cnt + 10'd1;
            cash_cnt     <= cash_cnt + denom(cur_sel);
         end
      end
   end

   assign bus.busy            = (state != IDLE);
   assign bus.note_req        = (state == REQ);
   assign bus.note_sel        = cur_sel;
   assign bus.done            = done_r;
   assign bus.error           = error_r;
   assign bus.err_code        = err_code_r;
   assign bus.notes_dispensed = notes_cnt;
   assign bus.cash_dispensed  = cash_cnt;
   assign bus.inv_100         = inv[0];
   assign bus.inv_50          = inv[1];
   assign bus.inv_20          = inv[2];
   assign bus.inv_10          = inv[3];
endmodule

// File: tb/tb_cash_dispense_sequencer.sv
module tb_cash_dispense_sequencer;
   localparam int AMT_W = 14;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cash_dispense_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

   cash_dispense_sequencer #(
      .AMT_W(AMT_W), .MAX_AMT(7000), .CNT_W(CNT_W), .INIT_NOTES(10), .ACK_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int denom_v [4] = '{100, 50, 20, 10};
   int m_inv [4];
   int m_q [$];
   int m_n;
   bit m_ok;

   typedef struct {
      bit rst_b;
      bit refill_b;
      int amt;
      int kmax;
      int jam;
      bit canc;
      bit refill_w;
      bit noise;
      int exp_code;
      int exp_notes;
      int exp_cash;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_inv();
      check("inv_100", bus.inv_100, m_inv[0]);
      check("inv_50",  bus.inv_50,  m_inv[1]);
      check("inv_20",  bus.inv_20,  m_inv[2]);
      check("inv_10",  bus.inv_10,  m_inv[3]);
   endtask

   // Greedy mix by whole denominations: for each note take as many as the
   // amount and stock allow. Notes are dispensed 100s first, then 50s, ...
   function automatic void model_plan(input int amt);
      int r;
      int n;
      r = amt;
      m_n = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
         n = r / denom_v[i];
         if (n > m_inv[i]) n = m_inv[i];
         r -= n * denom_v[i];
         m_n += n;
         for (int j = 0; j < n; j++) m_q.push_back(i);
      end
      m_ok = (r == 0);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_inv[i] = 10;
   endtask

   task automatic do_refill();
      bus.refill = 1'b1;
      tick();
      bus.refill = 1'b0;
      for (int i = 0; i < 4; i++) m_inv[i] = 10;
   endtask

   // One transaction. jam = index of the note that is never acked (-1: none).
   task automatic run_txn(input int amt, input int kmax, input int jam, input bit canc_req,
                          input bit refill_w, input bit noise,
                          output int code, output int notes, output int cash);
      int cyc, age, k, nreq, exp_cyc, rise_cyc, delivered, exp_cash, exp_req;
      bit bad, ended;
      bad = (amt == 0) || (amt > 7000) || (amt % 10 != 0);
      if (!bad) model_plan(amt);
      bus.amount = AMT_W'(amt);
      bus.start  = 1'b1;
      bus.refill = refill_w;
      tick();
      bus.start  = 1'b0;
      bus.refill = 1'b0;
      cyc = 1;
      if (bad) begin
         check("bad_err_pulse", bus.error, 1);
         check("bad_err_code", bus.err_code, 1);
         check("bad_busy", bus.busy, 0);
         tick();
         check("bad_pulse_len", bus.error, 0);
         check("bad_no_req", bus.note_req, 0);
         check_inv();
         code  = int'(bus.err_code);
         notes = int'(bus.notes_dispensed);
         cash  = int'(bus.cash_dispensed);
         return;
      end
      check("busy_after_accept", bus.busy, 1);
      age = 0; k = 0; nreq = 0; rise_cyc = 0; ended = 1'b0;
      exp_cyc = m_n + 1;
      while (!ended && cyc < 3000) begin
         if (bus.done || bus.error) begin
            ended = 1'b1;
         end else begin
            if (bus.note_req) begin
               if (age == 0) begin
                  rise_cyc = cyc;
                  check("note_sel", bus.note_sel, (nreq < m_q.size()) ? m_q[nreq] : 4);
                  k = int'($urandom_range(kmax, 0));
                  nreq++;
               end
               bus.note_ack = (age == k) && (nreq - 1 != jam);
               if (bus.note_ack) exp_cyc += k + 2;
               bus.cancel = canc_req;
               age++;
            end else begin
               age = 0;
               bus.note_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
               bus.cancel = 1'b0;
            end
            tick();
            cyc++;
         end
      end
      bus.note_ack = 1'b0;
      bus.cancel   = 1'b0;
      if (!ended) check("txn_cycle_budget", 0, 1);

      if (!m_ok)                     delivered = 0;
      else if (jam >= 0 && jam < m_n) delivered = jam;
      else                           delivered = m_n;
      exp_cash = 0;
      for (int i = 0; i < delivered; i++) begin
         exp_cash += denom_v[m_q[i]];
         m_inv[m_q[i]]--;
      end

      if (!m_ok) begin
         exp_req = 0;
         check("insuff_err", bus.error, 1);
         check("insuff_code", bus.err_code, 2);
         check("insuff_cycle", cyc, m_n + 2);
      end else if (jam >= 0 && jam < m_n) begin
         exp_req = jam + 1;
         check("jam_err", bus.error, 1);
         check("jam_code", bus.err_code, 3);
         check("jam_cycle", cyc, rise_cyc + 16);
      end else begin
         exp_req = m_n;
         check("done_pulse", bus.done, 1);
         check("done_code", bus.err_code, 0);
         check("done_cycle", cyc, exp_cyc + 1);
      end
      check("req_count", nreq, exp_req);
      check("busy_at_pulse", bus.busy, 0);
      check("notes_dispensed", bus.notes_dispensed, delivered);
      check("cash_dispensed", bus.cash_dispensed, exp_cash);
      code  = int'(bus.err_code);
      notes = int'(bus.notes_dispensed);
      cash  = int'(bus.cash_dispensed);
      tick();
      check("pulse_len", {30'd0, bus.done, bus.error}, 0);
      check_inv();
   endtask

   initial begin
      vec_t vecs [11];
      int code, notes, cash, guard, amt;
      bit pulse_seen;

      vecs[0]  = '{1, 0, 380,  0, -1, 0, 0, 0, 0, 6, 380};
      vecs[1]  = '{0, 0, 15,   0, -1, 0, 0, 0, 1, 0, 0};
      vecs[2]  = '{0, 0, 7010, 0, -1, 0, 0, 0, 1, 0, 0};
      vecs[3]  = '{1, 0, 1900, 0, -1, 0, 0, 0, 2, 0, 0};
      vecs[4]  = '{0, 1, 1100, 0, -1, 0, 0, 0, 0, 12, 1100};
      vecs[5]  = '{0, 1, 200,  0,  1, 0, 0, 0, 3, 1, 100};
      vecs[6]  = '{0, 0, 500,  2, -1, 1, 0, 0, 0, 5, 500};
      vecs[7]  = '{0, 0, 60,   1, -1, 0, 1, 1, 0, 2, 60};
      vecs[8]  = '{0, 0, 0,    0, -1, 0, 0, 0, 1, 0, 0};
      vecs[9]  = '{0, 0, 6000, 1, -1, 0, 0, 0, 2, 0, 0};
      vecs[10] = '{0, 0, 70,   3, -1, 0, 0, 1, 0, 2, 70};

      bus.start = 1'b0; bus.amount = '0; bus.cancel = 1'b0;
      bus.refill = 1'b0; bus.note_ack = 1'b0;
      rst = 1'b1;
      tick();
      do_reset();

      check("rst_busy", bus.busy, 0);
      check("rst_note_req", bus.note_req, 0);
      check("rst_note_sel", bus.note_sel, 0);
      check("rst_done", bus.done, 0);
      check("rst_error", bus.error, 0);
      check("rst_err_code", bus.err_code, 0);
      check("rst_notes", bus.notes_dispensed, 0);
      check("rst_cash", bus.cash_dispensed, 0);
      check_inv();

      foreach (vecs[i]) begin
         if (vecs[i].rst_b) do_reset();
         if (vecs[i].refill_b) do_refill();
         run_txn(vecs[i].amt, vecs[i].kmax, vecs[i].jam, vecs[i].canc,
                 vecs[i].refill_w, vecs[i].noise, code, notes, cash);
         check($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
         check($sformatf("vec%0d_notes", i), notes, vecs[i].exp_notes);
         check($sformatf("vec%0d_cash", i), cash, vecs[i].exp_cash);
      end

      // Cancel while planning 500: back to IDLE quietly, nothing dispensed.
      do_refill();
      bus.amount = AMT_W'(500);
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      check("cancel_plan_busy", bus.busy, 0);
      pulse_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.done || bus.error || bus.note_req) pulse_seen = 1'b1;
         tick();
      end
      check("cancel_plan_no_pulse", pulse_seen, 0);
      check("cancel_plan_code", bus.err_code, 0);
      check("cancel_plan_notes", bus.notes_dispensed, 0);
      check_inv();

      // Reset while in GAP after the first note of 380.
      bus.amount = AMT_W'(380);
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      guard = 0;
      while (!bus.note_req && guard < 50) begin
         tick();
         guard++;
      end
      check("gap_req_seen", bus.note_req, 1);
      bus.note_ack = 1'b1;
      tick();
      bus.note_ack = 1'b0;
      check("gap_req_low", bus.note_req, 0);
      check("gap_busy", bus.busy, 1);
      do_reset();
      check("rst_gap_busy", bus.busy, 0);
      check("rst_gap_req", bus.note_req, 0);
      check("rst_gap_notes", bus.notes_dispensed, 0);
      check_inv();

      // Randomized transactions against the model.
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(3, 0) == 0) do_refill();
         if ($urandom_range(5, 0) == 0) amt = int'($urandom_range(8000, 0));
         else                           amt = 10 * int'($urandom_range(150, 1));
         run_txn(amt, int'($urandom_range(3, 0)),
                 ($urandom_range(4, 0) == 0) ? int'($urandom_range(5, 0)) : -1,
                 1'($urandom_range(1, 0)), 1'b0, 1'b1, code, notes, cash);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
